sort4_seq: RTL and testbench

Sequential 4-word sorter that sits on a serial stream: it collects four words over a valid/ready input, sorts them in place using one shared compare-and-swap unit over five cycles, then drains the sorted words over a valid/ready output. It is the serial-stream counterpart of the parallel 4-input sort network. It trades about five cycles of latency for a single comparator, and connects directly to word-serial producers and consumers.

---
 rtl/sort4_seq_pkg.sv | 24 ++
 rtl/sort4_seq_cas.sv | 21 ++
 rtl/sort4_seq.sv | 122 ++++++++++++
 tb/tb_sort4_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort4_seq_pkg.sv
// sort4_seq_pkg: shared types and constants for the sequential 4-word sorter.
// Holds the FSM state enum, frame/step sizes and the compare-and-swap step
// table that drives the single shared comparator.
package sort4_seq_pkg;

  // Frame and schedule sizes
  localparam int NUM_WORDS = 4;
  localparam int NUM_STEPS = 5;

  // Controller phases: collect a frame, sort it, hand it downstream
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Five-step sorting network for four words. Step k compares the registers
  // STEP_LO[k] and STEP_HI[k], leaving the min in the lower-indexed one.
  // Steps 0-1 sort the pairs, 2-3 place the global min/max at the ends and
  // step 4 orders the two middle words.
  localparam logic [1:0] STEP_LO [NUM_STEPS] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
  localparam logic [1:0] STEP_HI [NUM_STEPS] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2};

endpackage

// File: rtl/sort4_seq_cas.sv
// Compare_and_Swap_unit: purely combinational unsigned compare-and-swap.
// The sorter time-shares one instance across all five network steps.
module Compare_and_Swap_unit #(
  parameter int SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] i_a,
  input  logic [SIZE_DATA-1:0] i_b,
  output logic [SIZE_DATA-1:0] o_min,
  output logic [SIZE_DATA-1:0] o_max
);

  logic w_swap;

  // Swap only when strictly out of order; ties pass straight through
  always_comb begin
    w_swap = (i_a > i_b);
    o_min  = w_swap ? i_b : i_a;
    o_max  = w_swap ? i_a : i_b;
  end

endmodule

// File: rtl/sort4_seq.sv
// sort4_seq: word-serial 4-word sorter. Collects four words over a
// valid/ready input, sorts them in place with one shared compare-and-swap
// unit over five cycles, then drains them over a valid/ready output.
// Optional feature: define SORT4_SEQ_FLUSH_EN to add the synchronous
// i_flush port that aborts the current frame from any state.
module sort4_seq
  import sort4_seq_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter bit IS_ASC    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
`ifdef SORT4_SEQ_FLUSH_EN
  input  logic                 i_flush,
`endif
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  output logic                 o_busy
);

  state_t               r_state;
  logic [1:0]           r_cnt;
  logic [2:0]           r_step;
  logic [SIZE_DATA-1:0] r_word [NUM_WORDS];

  logic                 w_flush;
  logic [1:0]           w_lo;
  logic [1:0]           w_hi;
  logic [1:0]           w_idx;
  logic [SIZE_DATA-1:0] w_min;
  logic [SIZE_DATA-1:0] w_max;

`ifdef SORT4_SEQ_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Operand selection for the current network step
  always_comb begin
    w_lo = STEP_LO[r_step];
    w_hi = STEP_HI[r_step];
  end

  Compare_and_Swap_unit #(
    .SIZE_DATA (SIZE_DATA)
  ) u_cas (
    .i_a   (r_word[w_lo]),
    .i_b   (r_word[w_hi]),
    .o_min (w_min),
    .o_max (w_max)
  );

  // Output decode from the registered state; descending mode reads the
  // sorted registers back to front
  always_comb begin
    w_idx   = IS_ASC ? r_cnt : (2'd3 - r_cnt);
    o_ready = (r_state == LOAD);
    o_valid = (r_state == DRAIN);
    o_last  = (r_state == DRAIN) && (r_cnt == 2'd3);
    o_data  = (r_state == DRAIN) ? r_word[w_idx] : '0;
    o_busy  = (r_state != LOAD) || (r_cnt != 2'd0);
  end

  // Frame controller: load, in-place sort and drain with flush override
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LOAD;
      r_cnt   <= 2'd0;
      r_step  <= 3'd0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_word[k] <= '0;
      end
    end else if (w_flush) begin
      r_state <= LOAD;
      r_cnt   <= 2'd0;
      r_step  <= 3'd0;
    end else begin
      case (r_state)
        LOAD: begin
          if (i_valid) begin
            r_word[r_cnt] <= i_data;
            r_cnt         <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= SORT;
            end
          end
        end
        SORT: begin
          r_word[w_lo] <= w_min;
          r_word[w_hi] <= w_max;
          if (r_step == 3'(NUM_STEPS - 1)) begin
            r_step  <= 3'd0;
            r_state <= DRAIN;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        DRAIN: begin
          if (i_ready) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= LOAD;
            end
          end
        end
        default: begin
          r_state <= LOAD;
          r_cnt   <= 2'd0;
          r_step  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq.sv
// tb_sort4_seq: self-checking bench for sort4_seq. An ascending and a
// descending instance share one stimulus stream; a queue-based frame model
// predicts every output each cycle, and directed frames pin the model with
// hand-computed results. Define SORT4_SEQ_FLUSH_EN to exercise i_flush.
module tb_sort4_seq;

  logic       clk;
  logic       rstN;
  logic       iValid;
  logic [7:0] iData;
  logic       iReady;
  logic       iFlush;

  logic       aReady, aValid, aLast, aBusy;
  logic [7:0] aData;
  logic       dReady, dValid, dLast, dBusy;
  logic [7:0] dData;

  int nChecks;
  int nFails;

  // Behavioural model: words collected so far, the sorted frame waiting out
  // the sort delay, and the words still owed downstream by each instance
  logic [7:0] mIn[$];
  logic [7:0] mPend[$];
  logic [7:0] mAsc[$];
  logic [7:0] mDesc[$];
  int         mSortWait;

  // Words actually handed downstream, for directed frame checks
  logic [7:0] gotAsc[$];
  logic [7:0] gotDesc[$];
  logic       gotLast[$];

  logic       expValid, expReady, expBusy, expLast;
  logic [7:0] expDataA, expDataD;

  sort4_seq #(.SIZE_DATA(8), .IS_ASC(1'b1)) dutAsc (
    .i_clk   (clk),
    .i_rst_n (rstN),
`ifdef SORT4_SEQ_FLUSH_EN
    .i_flush (iFlush),
`endif
    .i_valid (iValid),
    .o_ready (aReady),
    .i_data  (iData),
    .o_valid (aValid),
    .i_ready (iReady),
    .o_data  (aData),
    .o_last  (aLast),
    .o_busy  (aBusy)
  );

  sort4_seq #(.SIZE_DATA(8), .IS_ASC(1'b0)) dutDesc (
    .i_clk   (clk),
    .i_rst_n (rstN),
`ifdef SORT4_SEQ_FLUSH_EN
    .i_flush (iFlush),
`endif
    .i_valid (iValid),
    .o_ready (dReady),
    .i_data  (iData),
    .o_valid (dValid),
    .i_ready (iReady),
    .o_data  (dData),
    .o_last  (dLast),
    .o_busy  (dBusy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic clearModel();
    mIn.delete();
    mPend.delete();
    mAsc.delete();
    mDesc.delete();
    mSortWait = 0;
  endtask

  // Per-cycle compare against the model, then advance the model by the
  // handshakes that the coming rising edge will perform
  always @(negedge clk) begin
    expValid = (mAsc.size() != 0);
    expReady = !expValid && (mSortWait == 0);
    expBusy  = !expReady || (mIn.size() != 0);
    expLast  = expValid && (mAsc.size() == 1);
    expDataA = expValid ? mAsc[0] : 8'd0;
    expDataD = expValid ? mDesc[0] : 8'd0;

    checkOutput("asc_valid", 32'(aValid), 32'(expValid));
    checkOutput("asc_ready", 32'(aReady), 32'(expReady));
    checkOutput("asc_busy",  32'(aBusy),  32'(expBusy));
    checkOutput("asc_last",  32'(aLast),  32'(expLast));
    checkOutput("asc_data",  32'(aData),  32'(expDataA));
    checkOutput("desc_valid", 32'(dValid), 32'(expValid));
    checkOutput("desc_ready", 32'(dReady), 32'(expReady));
    checkOutput("desc_busy",  32'(dBusy),  32'(expBusy));
    checkOutput("desc_last",  32'(dLast),  32'(expLast));
    checkOutput("desc_data",  32'(dData),  32'(expDataD));

    if (rstN && !iFlush && aValid && iReady) begin
      gotAsc.push_back(aData);
      gotLast.push_back(aLast);
    end
    if (rstN && !iFlush && dValid && iReady) begin
      gotDesc.push_back(dData);
    end

    if (rstN) begin
      if (iFlush) begin
        clearModel();
      end else if (expValid) begin
        if (iReady) begin
          void'(mAsc.pop_front());
          void'(mDesc.pop_front());
        end
      end else if (mSortWait != 0) begin
        mSortWait--;
        if (mSortWait == 0) begin
          mAsc = mPend;
          mDesc.delete();
          for (int i = mPend.size() - 1; i >= 0; i--) begin
            mDesc.push_back(mPend[i]);
          end
        end
      end else if (iValid) begin
        mIn.push_back(iData);
        if (mIn.size() == 4) begin
          mPend = mIn;
          mPend.sort();
          mSortWait = 5;
          mIn.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    clearModel();
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic clearGot();
    gotAsc.delete();
    gotDesc.delete();
    gotLast.delete();
  endtask

  // Offer one word and hold it until the ascending instance takes it
  task automatic loadWord(input logic [7:0] d);
    int   guard;
    logic acc;
    guard  = 0;
    iValid = 1'b1;
    iData  = d;
    do begin
      @(negedge clk);
      acc = aReady;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) checkOutput("load_timeout", 32'd0, 32'd1);
    iValid = 1'b0;
  endtask

  task automatic loadFrame(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    loadWord(w0);
    loadWord(w1);
    loadWord(w2);
    loadWord(w3);
  endtask

  // Let the current frame drain with downstream always ready
  task automatic drainFrame();
    int guard;
    guard  = 0;
    iReady = 1'b1;
    while (gotAsc.size() < 4 && guard < 40) begin
      tick();
      guard++;
    end
    if (gotAsc.size() < 4) checkOutput("drain_timeout", 32'(gotAsc.size()), 32'd4);
    tick();
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input bit desc);
    logic [7:0] exp [4];
    exp = '{e0, e1, e2, e3};
    if (desc) begin
      checkOutput({tag, "_count"}, 32'(gotDesc.size()), 32'd4);
      for (int i = 0; i < 4 && i < gotDesc.size(); i++)
        checkOutput({tag, "_word"}, 32'(gotDesc[i]), 32'(exp[i]));
    end else begin
      checkOutput({tag, "_count"}, 32'(gotAsc.size()), 32'd4);
      for (int i = 0; i < 4 && i < gotAsc.size(); i++)
        checkOutput({tag, "_word"}, 32'(gotAsc[i]), 32'(exp[i]));
    end
  endtask

  // Random traffic: gappy input, bursty backpressure, extremes favoured
  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      iValid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       iData = 8'd0;
        1:       iData = 8'd255;
        2:       iData = 8'($urandom_range(0, 3));
        default: iData = 8'($urandom_range(0, 255));
      endcase
      iReady = ($urandom_range(0, 3) != 0);
`ifdef SORT4_SEQ_FLUSH_EN
      iFlush = ($urandom_range(0, 63) == 0);
`endif
      tick();
    end
    iValid = 1'b0;
    iReady = 1'b1;
    iFlush = 1'b0;
    repeat (20) tick();
  endtask

  initial begin
    int n;
    nChecks = 0;
    nFails  = 0;
    rstN    = 1'b0;
    iValid  = 1'b0;
    iData   = 8'd0;
    iReady  = 1'b1;
    iFlush  = 1'b0;
    clearModel();
    clearGot();
    repeat (2) tick();
    rstN = 1'b1;
    tick();

    // Basic frame, latency and o_last placement
    $display("[TB] directed: 9,3,7,1");
    clearGot();
    loadFrame(8'd9, 8'd3, 8'd7, 8'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!aValid && n < 20);
    checkOutput("latency", 32'(n), 32'd6);
    drainFrame();
    checkFrame("asc_9371", 8'd1, 8'd3, 8'd7, 8'd9, 1'b0);
    checkFrame("desc_9371", 8'd9, 8'd7, 8'd3, 8'd1, 1'b1);
    if (gotLast.size() == 4) begin
      checkOutput("last_on_9", 32'(gotLast[3]), 32'd1);
      checkOutput("last_not_1", 32'(gotLast[0]), 32'd0);
    end else begin
      checkOutput("last_count", 32'(gotLast.size()), 32'd4);
    end

    // Duplicates and extremes
    $display("[TB] directed: duplicates and extremes");
    clearGot();
    loadFrame(8'd255, 8'd0, 8'd255, 8'd0);
    drainFrame();
    checkFrame("asc_ext", 8'd0, 8'd0, 8'd255, 8'd255, 1'b0);
    clearGot();
    loadFrame(8'd5, 8'd5, 8'd5, 8'd5);
    drainFrame();
    checkFrame("asc_fives", 8'd5, 8'd5, 8'd5, 8'd5, 1'b0);

    // Backpressure while the word 3 is presented
    $display("[TB] directed: backpressure");
    clearGot();
    loadFrame(8'd9, 8'd3, 8'd7, 8'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!aValid && n < 20);
    tick();
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_data", 32'(aData), 32'd3);
      checkOutput("bp_ready_low", 32'(aReady), 32'd0);
      tick();
    end
    drainFrame();
    checkFrame("asc_bp", 8'd1, 8'd3, 8'd7, 8'd9, 1'b0);

    // Reset in the middle of sorting
    $display("[TB] directed: reset mid-sort");
    clearGot();
    loadFrame(8'd40, 8'd30, 8'd20, 8'd10);
    tick();
    tick();
    rstN = 1'b0;
    clearModel();
    #1;
    checkOutput("rst_valid_drop", 32'(aValid), 32'd0);
    checkOutput("rst_busy_drop", 32'(aBusy), 32'd0);
    tick();
    rstN = 1'b1;
    tick();
    clearGot();
    loadFrame(8'd4, 8'd2, 8'd8, 8'd6);
    drainFrame();
    checkFrame("asc_after_rst", 8'd2, 8'd4, 8'd6, 8'd8, 1'b0);

`ifdef SORT4_SEQ_FLUSH_EN
    // Flush a partial frame; the word offered alongside must be dropped
    $display("[TB] directed: flush");
    clearGot();
    loadWord(8'd8);
    loadWord(8'd9);
    iFlush = 1'b1;
    iValid = 1'b1;
    iData  = 8'd77;
    tick();
    iFlush = 1'b0;
    iValid = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", 32'(aBusy), 32'd0);
    tick();
    loadFrame(8'd5, 8'd1, 8'd4, 8'd2);
    drainFrame();
    checkFrame("asc_flush", 8'd1, 8'd2, 8'd4, 8'd5, 1'b0);
`endif

    // Randomized traffic against the model
    $display("[TB] random traffic");
    applyStimulus(3000);
    doReset();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
